// File: rtl/encoder3_seq.sv
// Sequential priority encoder: emits one 3-bit code beat per set bit of each
// accepted 8-bit word, scanning from LSB or MSB, with a single beat for zero words.
module encoder3_seq #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [7:0] IN_DATA,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [2:0] OUT_CODE,
    output logic       OUT_LAST,
    output logic       OUT_ZERO
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t     state, state_next;
    logic [7:0] pending, pending_next;
    logic       zero_q, zero_next;
    logic [2:0] sel_code;
    logic       one_hot;
    logic       accept;
    logic       handshake;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            pending  <= '0;
            zero_q   <= 1'b0;
            IN_READY <= 1'b0;
        end else begin
            state    <= state_next;
            pending  <= pending_next;
            zero_q   <= zero_next;
            IN_READY <= (state_next == IDLE);
        end
    end

    // Later loop iterations overwrite earlier ones, so the scan order picks the
    // winning bit: descending loop leaves the lowest set bit, ascending the highest.
    always_comb begin
        sel_code = '0;
        if (LSB_FIRST) begin
            for (int unsigned i = 8; i > 0; i--) begin
                if (pending[i-1]) sel_code = 3'(i - 1);
            end
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (pending[i]) sel_code = 3'(i);
            end
        end
    end

    assign one_hot   = (pending != '0) && ((pending & (pending - 8'd1)) == '0);
    assign OUT_VALID = (state == EMIT);
    assign accept    = (state == IDLE) && IN_READY && IN_VALID;
    assign handshake = OUT_VALID && OUT_READY;

    always_comb begin
        OUT_CODE = '0;
        OUT_LAST = 1'b0;
        OUT_ZERO = 1'b0;
        if (OUT_VALID) begin
            OUT_CODE = zero_q ? 3'd0 : sel_code;
            OUT_LAST = zero_q | one_hot;
            OUT_ZERO = zero_q;
        end
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        zero_next    = zero_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next   = EMIT;
                    pending_next = IN_DATA;
                    zero_next    = (IN_DATA == '0);
                end
            end
            EMIT: begin
                if (handshake) begin
                    pending_next = pending & ~(8'd1 << sel_code);
                    if (OUT_LAST) begin
                        state_next   = IDLE;
                        pending_next = '0;
                        zero_next    = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_encoder3_seq.sv
// Directed bench for encoder3_seq: LSB-first and MSB-first instances share stimulus.
module tb_encoder3_seq;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       IN_VALID;
    logic [7:0] IN_DATA;
    logic       OUT_READY;

    logic       l_ready, l_valid, l_last, l_zero;
    logic [2:0] l_code;
    logic       m_ready, m_valid, m_last, m_zero;
    logic [2:0] m_code;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    encoder3_seq #(.LSB_FIRST(1'b1)) dut_l (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(l_ready),
        .IN_DATA(IN_DATA), .OUT_VALID(l_valid), .OUT_READY(OUT_READY),
        .OUT_CODE(l_code), .OUT_LAST(l_last), .OUT_ZERO(l_zero)
    );

    encoder3_seq #(.LSB_FIRST(1'b0)) dut_m (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(m_ready),
        .IN_DATA(IN_DATA), .OUT_VALID(m_valid), .OUT_READY(OUT_READY),
        .OUT_CODE(m_code), .OUT_LAST(m_last), .OUT_ZERO(m_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Checks one presented beat on both instances.
    task automatic beat(input string tag, input logic [2:0] lc, input logic [2:0] mc,
                        input logic last, input logic zero);
        check({tag, " l_valid"}, l_valid, 1'b1);
        check({tag, " l_code"},  l_code,  lc);
        check({tag, " l_last"},  l_last,  last);
        check({tag, " l_zero"},  l_zero,  zero);
        check({tag, " m_valid"}, m_valid, 1'b1);
        check({tag, " m_code"},  m_code,  mc);
        check({tag, " m_last"},  m_last,  last);
        check({tag, " m_zero"},  m_zero,  zero);
        check({tag, " ready"},   {l_ready, m_ready}, 2'b00);
    endtask

    task automatic idle_check(input string tag);
        check({tag, " valid"}, {l_valid, m_valid}, 2'b00);
        check({tag, " ready"}, {l_ready, m_ready}, 2'b11);
        check({tag, " code"},  {l_code, m_code}, 6'd0);
        check({tag, " flags"}, {l_last, l_zero, m_last, m_zero}, 4'd0);
    endtask

    task automatic send(input logic [7:0] data);
        IN_VALID = 1'b1;
        IN_DATA  = data;
        step();
        IN_VALID = 1'b0;
        IN_DATA  = '0;
    endtask

    initial begin
        RST_N     = 1'b0;
        IN_VALID  = 1'b0;
        IN_DATA   = '0;
        OUT_READY = 1'b1;
        step();
        step();
        check("rst ready", {l_ready, m_ready}, 2'b00);
        check("rst valid", {l_valid, m_valid}, 2'b00);
        check("rst code",  {l_code, m_code}, 6'd0);

        RST_N = 1'b1;
        #1;
        check("release ready before edge", {l_ready, m_ready}, 2'b00);
        step();
        idle_check("release");

        // single bit
        send(8'b0000_0100);
        beat("single", 3'd2, 3'd2, 1'b1, 1'b0);
        step();
        idle_check("single done");

        // multi-bit, with IN_VALID held high during EMIT to show it is ignored
        send(8'b1000_0101);
        IN_VALID = 1'b1;
        IN_DATA  = 8'h0F;
        beat("multi b0", 3'd0, 3'd7, 1'b0, 1'b0);
        step();
        beat("multi b1", 3'd2, 3'd2, 1'b0, 1'b0);
        step();
        beat("multi b2", 3'd7, 3'd0, 1'b1, 1'b0);
        step();
        IN_VALID = 1'b0;
        IN_DATA  = '0;
        idle_check("multi done");

        // zero word
        send(8'h00);
        beat("zero", 3'd0, 3'd0, 1'b1, 1'b1);
        step();
        idle_check("zero done");

        // full word with backpressure on the second beat
        send(8'hFF);
        beat("ff b0", 3'd0, 3'd7, 1'b0, 1'b0);
        step();
        OUT_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            beat("ff hold", 3'd1, 3'd6, 1'b0, 1'b0);
            step();
        end
        OUT_READY = 1'b1;
        for (int k = 1; k < 8; k++) begin
            beat("ff seq", 3'(k), 3'(7 - k), (k == 7), 1'b0);
            step();
        end
        idle_check("ff done");

        // reset in the middle of a word
        send(8'hFF);
        beat("rst b0", 3'd0, 3'd7, 1'b0, 1'b0);
        step();
        beat("rst b1", 3'd1, 3'd6, 1'b0, 1'b0);
        step();
        #2;
        RST_N = 1'b0;
        #1;
        check("async rst valid", {l_valid, m_valid}, 2'b00);
        check("async rst code",  {l_code, m_code}, 6'd0);
        check("async rst ready", {l_ready, m_ready}, 2'b00);
        step();
        RST_N = 1'b1;
        step();
        idle_check("after rst");
        send(8'b0001_0000);
        beat("fresh", 3'd4, 3'd4, 1'b1, 1'b0);
        step();
        idle_check("fresh done");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
